march_bist_ctrl: RTL and testbench



---
 rtl/march_bist_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March C- built-in self-test controller for a single-port
// memory with a shared bidirectional data bus. Runs E0..E5 over all N words,
// stops at the first mismatch and reports address, element and background.
// Optional feature macro: BIST_CHECKERBOARD_EN -- adds a second pass using a
// checkerboard background (bit i = 1 for even i) after a passing solid pass.
module march_bist_ctrl #(
    parameter int a_width = 4,
    parameter int width   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [a_width-1:0] fail_addr,
    output logic [2:0]         fail_elem,
    output logic               fail_bg,
    output logic               mem_read,
    output logic               mem_write,
    output logic [a_width-1:0] mem_addr,
    inout  wire  [width-1:0]   mem_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_CMP,
        ST_DONE
    } state_t;

    localparam logic [a_width-1:0] ADDR_LAST = '1;
    localparam logic [2:0]         ELEM_LAST = 3'd5;

    // Checkerboard background: bit i is 1 for even i.
    function automatic logic [width-1:0] checker_pat();
        logic [width-1:0] p;
        for (int i = 0; i < width; i++) p[i] = (i % 2 == 0);
        return p;
    endfunction

    localparam logic [width-1:0] BG_CHECKER = checker_pat();

    // E3 and E4 walk the address space downwards; all others walk upwards.
    function automatic logic is_down(input logic [2:0] elem);
        return (elem == 3'd3) || (elem == 3'd4);
    endfunction

    function automatic logic [a_width-1:0] elem_first(input logic [2:0] elem);
        return is_down(elem) ? ADDR_LAST : '0;
    endfunction

    function automatic logic [a_width-1:0] elem_final(input logic [2:0] elem);
        return is_down(elem) ? '0 : ADDR_LAST;
    endfunction

    state_t             r_state, w_state_nx;
    logic [a_width-1:0] r_addr,  w_addr_nx;
    logic [2:0]         r_elem,  w_elem_nx;
    logic               r_bg,    w_bg_nx;
    logic [width-1:0]   r_wdata, w_wdata_nx;
    logic               r_mem_read, r_mem_write;
    logic               r_busy, r_done, r_fail;
    logic [a_width-1:0] r_fail_addr;
    logic [2:0]         r_fail_elem;

    logic               w_start_run, w_fail_hit, w_pass_end;
    logic               w_at_last;
    logic [a_width-1:0] w_addr_step;
    logic [width-1:0]   w_bg_pat, w_bg_pat_nx, w_exp;

    // Next-state, address walk and read-compare decision.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        w_state_nx  = r_state;
        w_addr_nx   = r_addr;
        w_elem_nx   = r_elem;
        w_bg_nx     = r_bg;
        w_start_run = 1'b0;
        w_fail_hit  = 1'b0;
        w_pass_end  = 1'b0;

        w_bg_pat    = r_bg ? BG_CHECKER : '0;
        // Reads in E2 and E4 expect ~B; E1, E3, E5 expect B.
        w_exp       = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? ~w_bg_pat : w_bg_pat;
        w_at_last   = (r_addr == elem_final(r_elem));
        w_addr_step = is_down(r_elem) ? r_addr - 1'b1 : r_addr + 1'b1;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_run = 1'b1;
                    w_state_nx  = ST_WR;
                    w_addr_nx   = '0;
                    w_elem_nx   = 3'd0;
                    w_bg_nx     = 1'b0;
                end
            end
            ST_WR: begin
                // A write always ends the work for the current address.
                if (w_at_last) begin
                    w_elem_nx  = r_elem + 3'd1;
                    w_addr_nx  = elem_first(r_elem + 3'd1);
                    w_state_nx = ST_RD_ISSUE;
                end else begin
                    w_addr_nx  = w_addr_step;
                    w_state_nx = (r_elem == 3'd0) ? ST_WR : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: w_state_nx = ST_RD_CMP;
            ST_RD_CMP: begin
                if (mem_data != w_exp) begin
                    // The element's pending write is abandoned.
                    w_fail_hit = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (r_elem != ELEM_LAST) begin
                    w_state_nx = ST_WR;
                end else if (!w_at_last) begin
                    w_addr_nx  = w_addr_step;
                    w_state_nx = ST_RD_ISSUE;
                end else begin
`ifdef BIST_CHECKERBOARD_EN
                    if (!r_bg) begin
                        w_bg_nx    = 1'b1;
                        w_elem_nx  = 3'd0;
                        w_addr_nx  = '0;
                        w_state_nx = ST_WR;
                    end else begin
                        w_pass_end = 1'b1;
                        w_state_nx = ST_DONE;
                    end
`else
                    w_pass_end = 1'b1;
                    w_state_nx = ST_DONE;
`endif
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Write data for the op that the next state performs.
        w_bg_pat_nx = w_bg_nx ? BG_CHECKER : '0;
        w_wdata_nx  = w_elem_nx[0] ? ~w_bg_pat_nx : w_bg_pat_nx;
    end

    // State, counters and registered memory-side pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_elem      <= 3'd0;
            r_bg        <= 1'b0;
            r_wdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values computed above, independent of order.
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_elem      <= w_elem_nx;
            r_bg        <= w_bg_nx;
            r_wdata     <= w_wdata_nx;
            r_mem_read  <= (w_state_nx == ST_RD_ISSUE) || (w_state_nx == ST_RD_CMP);
            r_mem_write <= (w_state_nx == ST_WR);
        end
    end

    // Run status and first-failure record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else if (w_start_run) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else if (w_fail_hit) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_addr <= r_addr;
            r_fail_elem <= r_elem;
        end else if (w_pass_end) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
        end
    end

`ifdef BIST_CHECKERBOARD_EN
    logic r_fail_bg;

    // Background of the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_fail_bg <= 1'b0;
        else if (w_start_run) r_fail_bg <= 1'b0;
        else if (w_fail_hit)  r_fail_bg <= r_bg;
    end

    assign fail_bg = r_fail_bg;
`else
    assign fail_bg = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_addr;
    assign mem_data  = r_mem_write ? r_wdata : 'z;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// tb_march_bist_ctrl: self-checking bench for march_bist_ctrl with a
// behavioural single-port memory carrying an optional stuck-at bit, and an
// algorithm-level March C- reference model predicting outcome and latency.
module tb_march_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 4;
    localparam int N  = 1 << AW;
`ifdef BIST_CHECKERBOARD_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, fail_bg, mem_read, mem_write;
    logic [AW-1:0] fail_addr, mem_addr;
    logic [2:0]    fail_elem;
    wire  [DW-1:0] mem_data;

    march_bist_ctrl #(.a_width(AW), .width(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bg(fail_bg),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_read && mem_write) both_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // ---------------- memory under test with optional stuck-at bit ----------
    bit            f_en;
    int            f_addr;
    logic [DW-1:0] f_mask;
    logic          f_val;

    function automatic logic [DW-1:0] fault_apply(input int a, input logic [DW-1:0] d);
        if (f_en && a == f_addr) return (d & ~f_mask) | (f_val ? f_mask : '0);
        return d;
    endfunction

    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_q;
    logic          rd_v = 1'b0;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= fault_apply(int'(mem_addr), mem_data);
        if (mem_read)  rd_q <= mem[mem_addr];
        rd_v <= mem_read;
    end

    assign mem_data = (rd_v && mem_read && !mem_write) ? rd_q : 'z;

    // ---------------- algorithm-level reference model ------------------------
    logic [DW-1:0] m_mem [N];
    int            m_lat, m_addr, m_elem;
    bit            m_fail, m_bg;

    function automatic logic [DW-1:0] bg_pat(input bit cb);
        logic [DW-1:0] p;
        for (int i = 0; i < DW; i++) p[i] = cb && (i % 2 == 0);
        return p;
    endfunction

    task automatic model_run();
        int rd_op [6] = '{-1, 0, 1, 0, 1, 0};
        int wr_op [6] = '{ 0, 1, 0, 1, 0, -1};
        logic [DW-1:0] b, want;
        m_lat = 0; m_fail = 0; m_addr = 0; m_elem = 0; m_bg = 0;
        for (int p = 0; p < PASSES; p++) begin
            b = bg_pat(p == 1);
            for (int e = 0; e < 6; e++) begin
                for (int k = 0; k < N; k++) begin
                    int a;
                    a = (e == 3 || e == 4) ? N - 1 - k : k;
                    if (rd_op[e] >= 0) begin
                        m_lat += 2;
                        want = rd_op[e] ? ~b : b;
                        if (m_mem[a] !== want) begin
                            m_fail = 1; m_addr = a; m_elem = e; m_bg = (p == 1);
                            return;
                        end
                    end
                    if (wr_op[e] >= 0) begin
                        m_lat += 1;
                        m_mem[a] = fault_apply(a, wr_op[e] ? ~b : b);
                    end
                end
            end
        end
    endtask

    // ---------------- one BIST run --------------------------------------------
    task automatic run_one(input string tag, input bit fen, input int fa, input int fb,
                           input bit fv, input bit pulse_mid, input int spec_lat);
        int e_cyc, lat_obs, bad;
        f_en = fen; f_addr = fa; f_mask = '0; f_mask[fb] = 1'b1; f_val = fv;
        model_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; e_cyc = cyc;
        check({tag, ":busy_after_E"}, busy, 1);
        check({tag, ":done_cleared"}, done, 0);
        while (!done && (cyc - e_cyc) < m_lat + 20) begin
            start = pulse_mid && ((cyc - e_cyc) == m_lat / 2);
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            check({tag, ":timeout"}, 0, 1);
            rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
            return;
        end
        lat_obs = cyc - e_cyc;
        check({tag, ":latency"}, lat_obs, m_lat);
        if (spec_lat > 0) check({tag, ":latency_abs"}, lat_obs, spec_lat);
        check({tag, ":fail"}, fail, m_fail);
        check({tag, ":busy_at_done"}, busy, 0);
        check({tag, ":fail_addr"}, fail_addr, m_fail ? m_addr : 0);
        check({tag, ":fail_elem"}, fail_elem, m_fail ? m_elem : 0);
        check({tag, ":fail_bg"}, fail_bg, m_fail ? m_bg : 0);
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== m_mem[i]) bad++;
        check({tag, ":final_mem"}, bad, 0);
    endtask

    initial begin
        int bad;
        // Reset state
        rst_n = 1'b0;
        #12;
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:fail", fail, 0);
        check("rst:fail_addr", fail_addr, 0);
        check("rst:fail_elem", fail_elem, 0);
        check("rst:fail_bg", fail_bg, 0);
        check("rst:rd_wr", {mem_read, mem_write}, 0);
        check("rst:mem_addr", mem_addr, 0);
        check("rst:bus_z", mem_data === 'z, 1);
        @(negedge clk); rst_n = 1'b1;

        // Idle for 50 cycles with start low
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || done || mem_read || mem_write) bad++;
        end
        check("idle50", bad, 0);

        // Directed cases
        run_one("clean",  0, 0,  0, 0, 1, 15 * N * PASSES);
        run_one("c5b0s1", 1, 5,  0, 1, 0, 33);
        run_one("c15b3s0",1, 15, 3, 0, 0, 111);
        run_one("c3b1s0", 1, 3,  1, 0, 0, 0);

        // Reset in the middle of a run
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst:busy", busy, 0);
        check("midrst:rd_wr", {mem_read, mem_write}, 0);
        check("midrst:addr", mem_addr, 0);
        check("midrst:bus_z", mem_data === 'z, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("midrst:no_done", bad, 0);
        run_one("after_rst", 0, 0, 0, 0, 1, 15 * N * PASSES);

        // Randomized fault injection
        for (int r = 0; r < 8; r++) begin
            bit fen;
            fen = ($urandom_range(0, 3) != 0);
            run_one($sformatf("rnd%0d", r), fen, $urandom_range(0, N - 1),
                    $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)), !fen, 0);
        end

        check("no_rd_wr_overlap", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
